// File: rtl/nios_system_key_capture.sv
// Avalon-MM input PIO: synchronises and debounces WIDTH key/switch inputs, latches
// qualifying edges of the debounced value and raises a maskable level interrupt.
module nios_system_key_capture #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1,
  parameter int IDLE_LEVEL      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IDLE    = (IDLE_LEVEL != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_RSVD = 2'd1,
    REG_MASK = 2'd2,
    REG_EDGE = 2'd3
  } reg_addr_e;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, edge_q;
  logic [WIDTH-1:0] edge_set, edge_clr;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic             wr;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    data_d = data_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != data_q[i]) begin
        if (cnt_q[i] == CNT_LAST) data_d[i] = sync2_q[i];
        else                      cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    edge_set = '0;
    if (EDGE_TYPE == 0)      edge_set = data_d & ~data_q;
    else if (EDGE_TYPE == 1) edge_set = ~data_d & data_q;
    else                     edge_set = data_d ^ data_q;
    edge_clr = (wr && address == REG_EDGE) ? writedata[WIDTH-1:0] : '0;
  end

  // NOTE: the debounce counter array is reset along with the flops, so a debounce
  // interrupted by reset restarts from zero rather than finishing on stale counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= IDLE;
      sync2_q <= IDLE;
      data_q  <= IDLE;
      mask_q  <= '0;
      edge_q  <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      data_q  <= data_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      if (wr && address == REG_MASK) mask_q <= writedata[WIDTH-1:0];
      // Set applied after clear: a new edge wins over a simultaneous W1C.
      edge_q <= (edge_q & ~edge_clr) | edge_set;
    end
  end

  always_comb begin
    readdata = '0;
    case (reg_addr_e'(address))
      REG_DATA: readdata[WIDTH-1:0] = data_q;
      REG_MASK: readdata[WIDTH-1:0] = mask_q;
      REG_EDGE: readdata[WIDTH-1:0] = edge_q;
      default:  readdata = '0;
    endcase
  end

  assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_nios_system_key_capture.sv
// Directed bench for nios_system_key_capture: WIDTH=4, DEBOUNCE_CYCLES=4, falling-edge
// capture, active-low keys idling high.
module tb_nios_system_key_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0]  in_port = 4'hF;
  logic        irq;

  int checks = 0;
  int errors = 0;

  nios_system_key_capture #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IDLE_LEVEL(1)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  // Advance through one rising edge and stop at the following falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic cs);
    address = a; writedata = d; chipselect = cs; write_n = 1'b0;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic do_reset();
    in_port = 4'hF;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    do_reset();
    bus_read(2'd0, rd); checks++;
    if (rd !== 32'h0000_000F) begin errors++; $display("FAIL reset_data: got %h expected %h", rd, 32'hF); end
    bus_read(2'd1, rd); checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_addr1: got %h expected %h", rd, 32'h0); end
    bus_read(2'd2, rd); checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_mask: got %h expected %h", rd, 32'h0); end
    bus_read(2'd3, rd); checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_edge: got %h expected %h", rd, 32'h0); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
  endtask

  task automatic test_press_latency();
    logic [31:0] rd;
    do_reset();
    in_port = 4'hE;
    tick(5);
    bus_read(2'd0, rd); checks++;
    if (rd !== 32'hF) begin errors++; $display("FAIL latency_early: got %h expected %h", rd, 32'hF); end
    tick(1);
    bus_read(2'd0, rd); checks++;
    if (rd !== 32'hE) begin errors++; $display("FAIL latency_data: got %h expected %h", rd, 32'hE); end
    bus_read(2'd3, rd); checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL press_edge: got %h expected %h", rd, 32'h1); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL press_irq_masked: got %b expected 0", irq); end
    bus_write(2'd2, 32'h1, 1'b1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL press_irq_unmasked: got %b expected 1", irq); end
    bus_read(2'd2, rd); checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL press_mask: got %h expected %h", rd, 32'h1); end
  endtask

  task automatic test_glitch();
    logic [31:0] rd;
    do_reset();
    in_port = 4'hD;
    tick(3);
    in_port = 4'hF;
    tick(8);
    bus_read(2'd0, rd); checks++;
    if (rd !== 32'hF) begin errors++; $display("FAIL glitch_data: got %h expected %h", rd, 32'hF); end
    bus_read(2'd3, rd); checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL glitch_edge: got %h expected %h", rd, 32'h0); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL glitch_irq: got %b expected 0", irq); end
  endtask

  task automatic test_w1c();
    logic [31:0] rd;
    do_reset();
    in_port = 4'hE;
    tick(6);
    bus_write(2'd2, 32'h1, 1'b1);
    bus_write(2'd3, 32'h0, 1'b1);
    bus_read(2'd3, rd); checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL w1c_zero_keeps: got %h expected %h", rd, 32'h1); end
    bus_write(2'd3, 32'h1, 1'b1);
    bus_read(2'd3, rd); checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL w1c_clear: got %h expected %h", rd, 32'h0); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b expected 0", irq); end
    in_port = 4'hF;
    tick(6);
    bus_read(2'd3, rd); checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rise_not_captured: got %h expected %h", rd, 32'h0); end
    // Second press: the W1C lands on the very edge DATA falls.
    in_port = 4'hE;
    tick(5);
    bus_write(2'd3, 32'h1, 1'b1);
    bus_read(2'd0, rd); checks++;
    if (rd !== 32'hE) begin errors++; $display("FAIL collide_data: got %h expected %h", rd, 32'hE); end
    bus_read(2'd3, rd); checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL collide_set_wins: got %h expected %h", rd, 32'h1); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL collide_irq: got %b expected 1", irq); end
  endtask

  task automatic test_reset_mid_debounce();
    logic [31:0] rd;
    do_reset();
    in_port = 4'hB;
    tick(4);
    reset = 1'b1;
    tick(1);
    in_port = 4'hF;
    tick(1);
    reset = 1'b0;
    bus_read(2'd0, rd); checks++;
    if (rd !== 32'hF) begin errors++; $display("FAIL midreset_data: got %h expected %h", rd, 32'hF); end
    tick(6);
    bus_read(2'd0, rd); checks++;
    if (rd !== 32'hF) begin errors++; $display("FAIL midreset_data_late: got %h expected %h", rd, 32'hF); end
    bus_read(2'd3, rd); checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL midreset_edge: got %h expected %h", rd, 32'h0); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b expected 0", irq); end
  endtask

  task automatic test_bus_ignore();
    logic [31:0] rd;
    do_reset();
    bus_write(2'd0, 32'h0, 1'b1);
    bus_read(2'd0, rd); checks++;
    if (rd !== 32'hF) begin errors++; $display("FAIL data_ro: got %h expected %h", rd, 32'hF); end
    bus_write(2'd2, 32'hF, 1'b0);
    bus_read(2'd2, rd); checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL cs_low_mask: got %h expected %h", rd, 32'h0); end
    bus_write(2'd1, 32'hF, 1'b1);
    bus_read(2'd1, rd); checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL addr1_ignored: got %h expected %h", rd, 32'h0); end
    bus_write(2'd2, 32'hFFFF_FFF8, 1'b1);
    bus_read(2'd2, rd); checks++;
    if (rd !== 32'h8) begin errors++; $display("FAIL mask_upper: got %h expected %h", rd, 32'h8); end
    in_port = 4'h7;
    tick(6);
    bus_read(2'd3, rd); checks++;
    if (rd !== 32'h8) begin errors++; $display("FAIL bit3_edge: got %h expected %h", rd, 32'h8); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL bit3_irq: got %b expected 1", irq); end
    bus_write(2'd3, 32'h8, 1'b1);
    in_port = 4'hF;
    tick(6);
    bus_read(2'd0, rd); checks++;
    if (rd !== 32'hF) begin errors++; $display("FAIL release_data: got %h expected %h", rd, 32'hF); end
    bus_read(2'd3, rd); checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL release_edge: got %h expected %h", rd, 32'h0); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL release_irq: got %b expected 0", irq); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_press_latency();
    test_glitch();
    test_w1c();
    test_reset_mid_debounce();
    test_bus_ignore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
